// File: rtl/sticky_scanner_pkg.sv
// sticky_scanner_pkg: shared FSM encoding and bank-index width for the sticky scanner.
package sticky_scanner_pkg;
    typedef enum logic [2:0] {IDLE, READ, CLEAR, NEXT, WAIT} state_t;
    localparam int IDX_W = 4;
endpackage

// File: rtl/sticky_scanner_if.sv
// sticky_scanner_if: sticky-bank bus, event stream and status signals of the scanner.
interface sticky_scanner_if #(
    parameter int WIDTH = 8,
    parameter int NBANK = 4
);
    import sticky_scanner_pkg::*;
    logic                scan_en;
    logic [NBANK-1:0]    upen;
    logic                upws;
    logic [WIDTH-1:0]    updi;
    logic [WIDTH-1:0]    updo;
    logic                ev_valid;
    logic                ev_ready;
    logic [IDX_W-1:0]    ev_bank;
    logic [WIDTH-1:0]    ev_bits;
    logic                irq;
    logic                ovf;
    logic                ovf_clr;
    modport master (
        input  scan_en, updo, ev_ready, ovf_clr,
        output upen, upws, updi, ev_valid, ev_bank, ev_bits, irq, ovf
    );
    modport slave (
        output scan_en, updo, ev_ready, ovf_clr,
        input  upen, upws, updi, ev_valid, ev_bank, ev_bits, irq, ovf
    );
endinterface

// File: rtl/sticky_scanner_evfifo.sv
// sticky_evfifo: power-of-2 event FIFO; push and pop may coincide at any occupancy.
module sticky_evfifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] count_nxt_o,
    output logic                   full_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;
    assign do_pop      = pop_i && count_q != '0;
    assign do_push     = push_i && (count_q != CW'(DEPTH) || do_pop);
    assign count_nxt_o = count_q + CW'(do_push) - CW'(do_pop);
    assign count_o     = count_q;
    assign full_o      = count_q == CW'(DEPTH);
    assign dout_o      = mem_q[rd_q];
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
            count_q <= count_nxt_o;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/sticky_scanner.sv
// sticky_scanner: round-robin scan of write-1-to-clear sticky banks, queueing nonzero
// banks as {bank, bits} events and clearing exactly the bits that were captured.
module sticky_scanner
    import sticky_scanner_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NBANK  = 4,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 16
) (
    input logic              clk,
    input logic              rst_,
    sticky_scanner_if.master bus
);
    localparam int TW = $clog2(PERIOD + 1);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             ovf_q, ovf_d, irq_q, irq_d, ovf_set;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             full;
    sticky_evfifo #(.W(WIDTH + IDX_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_        (rst_),
        .push_i      (state_q == CLEAR),
        .din_i       ({idx_q, cap_q}),
        .pop_i       (bus.ev_valid && bus.ev_ready),
        .dout_o      ({bus.ev_bank, bus.ev_bits}),
        .count_o     (cnt),
        .count_nxt_o (cnt_nxt),
        .full_o      (full)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        cap_d   = cap_q;
        ovf_set = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = bus.scan_en ? READ : IDLE;
                idx_d   = '0;
            end
            READ: begin
                // A full FIFO leaves the bank latched so the alarm is retried next pass
                cap_d   = bus.updo;
                ovf_set = bus.updo != '0 && full;
                state_d = (bus.updo != '0 && !full) ? CLEAR : NEXT;
            end
            CLEAR: state_d = NEXT;
            NEXT: begin
                state_d = (idx_q == IDX_W'(NBANK - 1)) ? WAIT : READ;
                idx_d   = (idx_q == IDX_W'(NBANK - 1)) ? '0 : idx_q + IDX_W'(1);
                timer_d = (idx_q == IDX_W'(NBANK - 1)) ? TW'(PERIOD) : timer_q;
            end
            WAIT: begin
                timer_d = timer_q - TW'(1);
                state_d = (timer_q == TW'(1)) ? (bus.scan_en ? READ : IDLE) : WAIT;
            end
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
        irq_d = (cnt_nxt != '0) | ovf_d;
    end
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            cap_q   <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            cap_q   <= cap_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end
    assign bus.upen     = (state_q == READ || state_q == CLEAR) ? NBANK'(1) << idx_q : '0;
    assign bus.upws     = state_q == CLEAR;
    assign bus.updi     = (state_q == CLEAR) ? cap_q : '0;
    assign bus.ev_valid = cnt != '0;
    assign bus.ovf      = ovf_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_sticky_scanner.sv
// tb_sticky_scanner: directed checks of scanning, partial clear, overflow and reset,
// with a behavioural model of four write-1-to-clear sticky banks.
module tb_sticky_scanner;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic init = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] banks [4];
    logic [7:0] set_v [4];
    logic [7:0] updo_m;
    logic        f_push = 1'b0, f_pop = 1'b0, f_full;
    logic [11:0] f_din = '0, f_dout;
    logic [2:0]  f_cnt, f_cnt_nxt;

    always #5 clk = ~clk;

    sticky_scanner_if #(.WIDTH(8), .NBANK(4)) bus();

    sticky_scanner #(.WIDTH(8), .NBANK(4), .DEPTH(4), .PERIOD(16)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.master)
    );

    sticky_evfifo #(.W(12), .DEPTH(4)) u_ff (
        .clk         (clk),
        .rst_        (rst_),
        .push_i      (f_push),
        .din_i       (f_din),
        .pop_i       (f_pop),
        .dout_o      (f_dout),
        .count_o     (f_cnt),
        .count_nxt_o (f_cnt_nxt),
        .full_o      (f_full)
    );

    // Sticky banks: new alarms OR in; a strobe clears only the bits in updi
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            banks[i] <= init ? 8'h00 :
                (((bus.upws && bus.upen[i]) ? (banks[i] & ~bus.updi) : banks[i]) | set_v[i]);
    end

    always_comb begin
        updo_m = '0;
        for (int i = 0; i < 4; i++)
            if (bus.upen[i]) updo_m = updo_m | banks[i];
    end
    assign bus.updo = updo_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int b, input logic [7:0] v);
        set_v[b] = v;
        step();
        set_v[b] = '0;
    endtask

    task automatic wait_upen(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.upen == v) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_upws(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.upws) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_ev(input logic [3:0] b, input logic [7:0] v, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.ev_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        n_chk++;
        if (!got || {bus.ev_bank, bus.ev_bits} !== {b, v})
            $display("FAIL %s got valid=%0b bank=%0d bits=%h exp bank=%0d bits=%h",
                     nm, got, bus.ev_bank, bus.ev_bits, b, v);
        else n_pass++;
        step();
    endtask

    task automatic test_reset();
        bus.scan_en = 1'b0;
        bus.ev_ready = 1'b1;
        bus.ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) set_v[i] = '0;
        step();
        step();
        n_chk++; if (bus.upen !== 4'h0) $display("FAIL rst_upen got=%h exp=0", bus.upen); else n_pass++;
        n_chk++; if (bus.upws !== 1'b0) $display("FAIL rst_upws got=%b exp=0", bus.upws); else n_pass++;
        n_chk++; if (bus.updi !== 8'h00) $display("FAIL rst_updi got=%h exp=00", bus.updi); else n_pass++;
        n_chk++; if (bus.ev_valid !== 1'b0) $display("FAIL rst_ev_valid got=%b exp=0", bus.ev_valid); else n_pass++;
        n_chk++; if (bus.irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", bus.irq); else n_pass++;
        n_chk++; if (bus.ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", bus.ovf); else n_pass++;
        rst_ = 1'b1;
        init = 1'b0;
        repeat (3) step();
        n_chk++; if (bus.upen !== 4'h0) $display("FAIL idle_hold upen got=%h exp=0", bus.upen); else n_pass++;
    endtask

    task automatic test_idle_pass();
        int cnt = 0, reads = 0;
        bit sw = 1'b0, multi = 1'b0;
        bus.scan_en = 1'b1;
        step();
        n_chk++; if (bus.upen !== 4'h1) $display("FAIL start_read upen got=%h exp=1", bus.upen); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt++;
            if (bus.upws) sw = 1'b1;
            if ($countones(bus.upen) > 1) multi = 1'b1;
            if (bus.upen != 0) reads++;
            if (bus.upen == 4'h1) break;
        end
        n_chk++; if (cnt !== 24) $display("FAIL pass_period got=%0d exp=24", cnt); else n_pass++;
        n_chk++; if (reads !== 4) $display("FAIL pass_reads got=%0d exp=4", reads); else n_pass++;
        n_chk++; if (sw !== 1'b0) $display("FAIL idle_upws got=%b exp=0", sw); else n_pass++;
        n_chk++; if (multi !== 1'b0) $display("FAIL upen_onehot got=%b exp=0", multi); else n_pass++;
    endtask

    task automatic test_single_event();
        bit ok, sw = 1'b0;
        raise(2, 8'h05);
        wait_upws(ok);
        n_chk++; if (!ok) $display("FAIL se_sync got=timeout exp=clear"); else n_pass++;
        n_chk++; if (bus.upen !== 4'h4) $display("FAIL se_upen got=%h exp=4", bus.upen); else n_pass++;
        n_chk++; if (bus.updi !== 8'h05) $display("FAIL se_updi got=%h exp=05", bus.updi); else n_pass++;
        wait_ev(4'd2, 8'h05, "se_event");
        n_chk++; if (banks[2] !== 8'h00) $display("FAIL se_bank_cleared got=%h exp=00", banks[2]); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.upws) sw = 1'b1;
        end
        n_chk++; if (sw !== 1'b0) $display("FAIL se_next_pass_upws got=%b exp=0", sw); else n_pass++;
        n_chk++; if (bus.ovf !== 1'b0) $display("FAIL se_ovf got=%b exp=0", bus.ovf); else n_pass++;
    endtask

    task automatic test_partial_clear();
        bit ok;
        raise(1, 8'h01);
        wait_upws(ok);
        n_chk++; if (!ok) $display("FAIL pc_sync got=timeout exp=clear"); else n_pass++;
        n_chk++; if (bus.upen !== 4'h2) $display("FAIL pc_upen got=%h exp=2", bus.upen); else n_pass++;
        n_chk++; if (bus.updi !== 8'h01) $display("FAIL pc_updi got=%h exp=01", bus.updi); else n_pass++;
        raise(1, 8'h80);
        n_chk++; if (banks[1] !== 8'h80) $display("FAIL pc_bank_kept got=%h exp=80", banks[1]); else n_pass++;
        wait_ev(4'd1, 8'h01, "pc_event1");
        wait_ev(4'd1, 8'h80, "pc_event2");
    endtask

    task automatic test_overflow();
        bit ok;
        bus.ev_ready = 1'b0;
        wait_upen(4'h8, ok);
        n_chk++; if (!ok) $display("FAIL ov_sync1 got=timeout exp=bank3"); else n_pass++;
        step();
        step();
        raise(0, 8'h01);
        raise(1, 8'h02);
        raise(2, 8'h03);
        raise(3, 8'h04);
        wait_upen(4'h8, ok);
        n_chk++; if (!ok) $display("FAIL ov_sync2 got=timeout exp=bank3"); else n_pass++;
        raise(0, 8'h40);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.ovf) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_chk++; if (!ok) $display("FAIL ov_set got=timeout exp=ovf"); else n_pass++;
        n_chk++; if (bus.irq !== 1'b1) $display("FAIL ov_irq got=%b exp=1", bus.irq); else n_pass++;
        repeat (3) step();
        n_chk++; if (banks[0] !== 8'h40) $display("FAIL ov_bank_latched got=%h exp=40", banks[0]); else n_pass++;
        bus.ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({bus.ev_valid, bus.ev_bank, bus.ev_bits} !== {1'b1, 4'(k), 8'(k + 1)})
                $display("FAIL ov_drain%0d got valid=%b bank=%0d bits=%h exp bank=%0d bits=%h",
                         k, bus.ev_valid, bus.ev_bank, bus.ev_bits, k, k + 1);
            else n_pass++;
            step();
        end
        n_chk++; if (bus.ev_valid !== 1'b0) $display("FAIL ov_empty got=%b exp=0", bus.ev_valid); else n_pass++;
        n_chk++; if (bus.ovf !== 1'b1) $display("FAIL ov_sticky got=%b exp=1", bus.ovf); else n_pass++;
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        n_chk++; if (bus.ovf !== 1'b0) $display("FAIL ov_clr got=%b exp=0", bus.ovf); else n_pass++;
        n_chk++; if (bus.irq !== 1'b0) $display("FAIL ov_irq_clr got=%b exp=0", bus.irq); else n_pass++;
        wait_ev(4'd0, 8'h40, "ov_retry_event");
    endtask

    task automatic test_fifo_bypass();
        for (int k = 0; k < 4; k++) begin
            f_push = 1'b1;
            f_din = 12'hA00 + 12'(k);
            step();
        end
        f_push = 1'b0;
        n_chk++; if (f_cnt !== 3'd4) $display("FAIL ff_fill_cnt got=%0d exp=4", f_cnt); else n_pass++;
        n_chk++; if (f_full !== 1'b1) $display("FAIL ff_full got=%b exp=1", f_full); else n_pass++;
        f_push = 1'b1;
        f_pop = 1'b1;
        f_din = 12'hA04;
        step();
        f_push = 1'b0;
        n_chk++; if (f_cnt !== 3'd4) $display("FAIL ff_bypass_cnt got=%0d exp=4", f_cnt); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            n_chk++;
            if (f_dout !== 12'hA00 + 12'(k)) $display("FAIL ff_order%0d got=%h exp=%h", k, f_dout, 12'hA00 + 12'(k));
            else n_pass++;
            step();
        end
        f_pop = 1'b0;
        n_chk++; if (f_cnt !== 3'd0) $display("FAIL ff_drain_cnt got=%0d exp=0", f_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        bit ok;
        raise(1, 8'h3C);
        wait_upws(ok);
        n_chk++; if (!ok) $display("FAIL rc_sync got=timeout exp=clear"); else n_pass++;
        #2;
        rst_ = 1'b0;
        #1;
        n_chk++;
        if ({bus.upen, bus.upws, bus.updi, bus.irq, bus.ovf} !== 15'h0)
            $display("FAIL rc_outputs got upen=%h upws=%b updi=%h irq=%b ovf=%b exp all 0",
                     bus.upen, bus.upws, bus.updi, bus.irq, bus.ovf);
        else n_pass++;
        n_chk++; if (bus.ev_valid !== 1'b0) $display("FAIL rc_ev_valid got=%b exp=0", bus.ev_valid); else n_pass++;
        @(negedge clk);
        rst_ = 1'b1;
        n_chk++; if (banks[1] !== 8'h3C) $display("FAIL rc_no_write got=%h exp=3c", banks[1]); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.upen != 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++; if (!ok || bus.upen !== 4'h1) $display("FAIL rc_restart got=%h exp=1", bus.upen); else n_pass++;
        wait_ev(4'd1, 8'h3C, "rc_event");
    endtask

    initial begin
        test_reset();
        test_idle_pass();
        test_single_event();
        test_partial_clear();
        test_overflow();
        test_fifo_bypass();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sticky_scanner.md
STICKY_SCANNER -- requirements
Module: sticky_scanner

Interface
REQ-001 Parameter WIDTH, default 8, bits per sticky bank.
REQ-002 Parameter NBANK, default 4, number of sticky banks scanned (2..16).
REQ-003 Parameter DEPTH, default 4, event FIFO entries (power of 2).
REQ-004 Parameter PERIOD, default 16, idle cycles between scan passes (>=1).
REQ-005 clk  in  1  clock; all state on posedge clk.
REQ-006 rst_  in  1  reset, asynchronous, active-low.
REQ-007 scan_en  in  1  1 = scanning allowed; sampled only in IDLE/WAIT.
REQ-008 upen  out  NBANK  one-hot enable, bit i selects sticky bank i.
REQ-009 upws  out  1  write strobe to selected bank.
REQ-010 updi  out  WIDTH  write data (write-1-to-clear mask).
REQ-011 updo  in  WIDTH  OR of all bank read buses; banks return 0 when unselected.
REQ-012 ev_valid  out  1  event FIFO head valid.
REQ-013 ev_ready  in  1  consumer accepts head when ev_valid & ev_ready.
REQ-014 ev_bank  out  4  bank index of head event.
REQ-015 ev_bits  out  WIDTH  alarm bits of head event.
REQ-016 irq  out  1  registered; 1 when FIFO non-empty or ovf set.
REQ-017 ovf  out  1  sticky overflow flag; cleared by ovf_clr.
REQ-018 ovf_clr  in  1  single-cycle clear of ovf.

Function
REQ-019 FSM states: IDLE, READ, CLEAR, NEXT, WAIT.
REQ-020 IDLE: all outputs to bus 0; scan_en=1 -> READ with bank index 0.
REQ-021 READ (1 cycle): upen = 1<<idx, upws=0, updi=0; updo registered into cap at clock edge.
REQ-022 READ -> CLEAR when updo!=0 and FIFO not full.
REQ-023 READ -> NEXT when updo==0.
REQ-024 READ with updo!=0 and FIFO full: no clear, bank left latched, ovf<=1, -> NEXT.
REQ-025 CLEAR (1 cycle): upen = 1<<idx, upws=1, updi=cap; same cycle push {idx, cap} into FIFO; -> NEXT.
REQ-026 Only bits in cap are cleared; alarms arriving after READ remain latched in the bank for the next pass.
REQ-027 NEXT (1 cycle, bus idle): idx==NBANK-1 -> idx<=0, timer<=PERIOD, -> WAIT; else idx<=idx+1, -> READ.
REQ-028 WAIT: timer decrements each cycle; at timer==1 -> READ if scan_en=1, else IDLE.
REQ-029 Never assert more than one upen bit; upws only in CLEAR.
REQ-030 Pass latency: 3 cycles per nonzero bank, 2 per zero bank, plus PERIOD.
REQ-031 FIFO: push and pop in same cycle allowed at any occupancy, including full (count unchanged, no overflow).
REQ-032 FIFO full test in READ uses occupancy after any pop in that cycle is excluded (conservative: full = count==DEPTH).
REQ-033 ev_valid = count!=0; ev_bank/ev_bits stable while ev_valid & ~ev_ready.
REQ-034 FIFO pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-035 ovf_clr and overflow set in same cycle: set wins.
REQ-036 irq <= (count_next!=0) | ovf_next, one cycle after cause.
REQ-037 scan_en deassert mid-pass: current pass completes, then IDLE.

Reset
REQ-038 rst_ low: state=IDLE, idx=0, timer=0, cap=0, FIFO empty, ovf=0, irq=0, upen=0, upws=0, updi=0.
REQ-039 Reset mid-CLEAR aborts write; no partial event retained.

Structure
REQ-040 FSM state encodings and bank-index width constant in shared package sticky_scanner_pkg.
REQ-041 FIFO is one sub-module, sticky_evfifo (parameters WIDTH+4, DEPTH).
REQ-042 All bus outputs registered (driven from state/idx/cap registers, no combinational path from updo).

Verification
REQ-043 Bank 2 latches 8'h05, others 0, ev_ready=1 -> one READ+CLEAR on bank 2 with updi=8'h05; event {2,8'h05}; bank 2 reads 0 next pass.
REQ-044 Bank 1 alarm 8'h01, then 8'h80 asserted in CLEAR cycle -> clear mask 8'h01 only; next pass yields event {1,8'h80}.
REQ-045 ev_ready=0, DEPTH=4, five banks-events generated -> 4 events queued, fifth bank not cleared, ovf=1, irq=1; after draining, fifth event delivered next pass.
REQ-046 FIFO full with pop and CLEAR push same cycle -> count stays 4, ovf stays 0.
REQ-047 All banks zero, PERIOD=16 -> pass of 2*NBANK cycles then 16 WAIT cycles, upws never 1.
REQ-048 rst_ low during CLEAR -> all outputs 0 next cycle asynchronously; ev_valid=0; scan restarts at bank 0.
